daddb_seq: RTL
==============

DADDB_SEQ -- requirements
Module: daddb_seq

Interface
REQ-001 SHALL have parameter LANES, default 4, number of adder-B lanes (legal 2, 4, 8).
REQ-002 SHALL have parameter LANEW, default 16, bits per lane (legal 8..32).
REQ-003 SHALL have parameter CNTW, default 6, width of burst beat count.
REQ-004 SHALL use one clock; reset is asynchronous and active-high, ports named sys_clk and reset.
REQ-005 Ports:
- sys_clk  in  1  clock
- reset  in  1  async active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_sel  in  3  operand select
- cmd_count  in  CNTW  beats minus one
- srcd  in  LANES*LANEW  source data, lane k = bits [k*LANEW +: LANEW]
- iinc  in  32  intensity increment (16.16)
- zinc  in  32  Z increment (16.16)
- out_valid  out  1  beat present
- out_ready  in  1  consumer accepts beat
- addb  out  LANES*LANEW  B operand, same lane order as srcd
- out_last  out  1  final beat of burst
- busy  out  1  burst in progress

Function
REQ-006 SHALL implement states IDLE and BURST; IDLE->BURST on command accept; BURST->IDLE on final beat accepted with no new command accepted in the same cycle.
REQ-007 cmd_ready SHALL equal (!out_valid || (out_ready && out_last)) while reset is low, and 0 while reset is high.
REQ-008 On accept SHALL latch cmd_sel, cmd_count, srcd, iinc, zinc; later input changes SHALL not affect the burst.
REQ-009 First beat SHALL be registered at the accepting edge (out_valid high the following cycle); latency 1 cycle.
REQ-010 SHALL emit exactly cmd_count+1 beats; a beat advances only on out_valid && out_ready; throughput 1 beat/cycle.
REQ-011 While out_valid && !out_ready, addb, out_last SHALL hold stable.
REQ-012 out_last SHALL be high only on the final beat; cmd_count=0 gives one beat with out_last high.
REQ-013 A command accepted in the same cycle as the final beat SHALL load its first beat with no bubble cycle.
REQ-014 Selection, beat n (0-based):
- 000: lane k = latched srcd lane k, every beat.
- 001: all lanes = iinc[31:16] (zero-extend/truncate to LANEW), every beat.
- 010: even lanes = zinc[15:0], odd lanes = zinc[31:16] (zero-extend/truncate), every beat.
- 011: 16-bit accumulator ai = (n+1)*iinc[31:16] mod 2^16; all lanes = ai.
- 100: 32-bit accumulator az = (n+1)*zinc mod 2^32; even lanes = az[15:0], odd lanes = az[31:16].
- 101, 110, 111: all lanes zero.
REQ-015 Accumulators SHALL load the increment at command accept and add it once per accepted beat; overflow SHALL wrap silently; no multiplier.
REQ-016 busy SHALL equal out_valid.

Reset
REQ-017 reset high SHALL asynchronously force out_valid=0, out_last=0, busy=0, addb=0, accumulators=0, state IDLE.
REQ-018 reset mid-burst SHALL discard remaining beats; first command after release SHALL start at beat 0.

Verification (LANES=4, LANEW=16)
REQ-019 sel=000, count=0, srcd=64'h4444_3333_2222_1111 -> one beat addb=64'h4444_3333_2222_1111, out_last=1, cmd_ready high with out_ready.
REQ-020 sel=011, iinc=32'h0003_8000, count=3, out_ready=1 -> four consecutive beats, all lanes 0003, 0006, 0009, 000C; out_last on 4th only.
REQ-021 sel=100, zinc=32'h0001_8000, count=1 -> beat0 addb=64'h0001_8000_0001_8000, beat1 addb=64'h0003_0000_0003_0000.
REQ-022 sel=011, iinc=32'hFFFF_0000, count=1, out_ready low 5 cycles after beat0 -> beat0 lanes FFFF held 5 cycles, beat1 lanes FFFE (wrap), none lost or duplicated.
REQ-023 second command (sel=001, iinc=32'h0007_0000) valid during final beat of first burst -> its beat (lanes 0007) appears next cycle, no idle cycle.
REQ-024 reset pulse during beat 2 of a 4-beat burst -> out_valid low immediately; new count=0 command afterwards produces one beat with beat-0 value.

Source files
------------

// File: rtl/daddb_seq.sv
// Adder-B operand sequencer: accepts a burst command and streams cmd_count+1 beats
// of lane-replicated B operands built from source data, intensity and Z increments.
module daddb_seq #(
  parameter int LANES = 4,
  parameter int LANEW = 16,
  parameter int CNTW  = 6
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_sel,
  input  logic [CNTW-1:0]        cmd_count,
  input  logic [LANES*LANEW-1:0] srcd,
  input  logic [31:0]            iinc,
  input  logic [31:0]            zinc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*LANEW-1:0] addb,
  output logic                   out_last,
  output logic                   busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state;
  logic [2:0]             sel_q;
  logic [CNTW-1:0]        cnt_q;
  logic [LANES*LANEW-1:0] srcd_q;
  logic [15:0]            iinc_q;
  logic [31:0]            zinc_q;
  logic [15:0]            ai;
  logic [31:0]            az;

  logic                   accept;
  logic                   advance;
  logic [2:0]             sel_m;
  logic [LANES*LANEW-1:0] srcd_m;
  logic [15:0]            iinc_m;
  logic [31:0]            zinc_m;
  logic [15:0]            ai_m;
  logic [31:0]            az_m;
  logic [LANES*LANEW-1:0] addb_next;

  // Only the integer half of the intensity increment is ever used.
  logic unused_bits;
  assign unused_bits = ^iinc[15:0];

  assign cmd_ready = reset ? 1'b0 : (!out_valid || (out_ready && out_last));
  assign accept    = cmd_valid && cmd_ready;
  assign advance   = out_valid && out_ready;
  assign busy      = (state == BURST);

  // One beat builder shared by the first beat (fresh command) and later beats (latched).
  assign sel_m  = accept ? cmd_sel      : sel_q;
  assign srcd_m = accept ? srcd         : srcd_q;
  assign iinc_m = accept ? iinc[31:16]  : iinc_q;
  assign zinc_m = accept ? zinc         : zinc_q;
  assign ai_m   = accept ? iinc[31:16]  : ai + iinc_q;
  assign az_m   = accept ? zinc         : az + zinc_q;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam bit ODD = (gi % 2) == 1;
      logic [LANEW-1:0] lane_val;
      always_comb begin
        case (sel_m)
          3'b000:  lane_val = srcd_m[gi*LANEW +: LANEW];
          3'b001:  lane_val = LANEW'(iinc_m);
          3'b010:  lane_val = LANEW'(ODD ? zinc_m[31:16] : zinc_m[15:0]);
          3'b011:  lane_val = LANEW'(ai_m);
          3'b100:  lane_val = LANEW'(ODD ? az_m[31:16] : az_m[15:0]);
          default: lane_val = '0;
        endcase
      end
      assign addb_next[gi*LANEW +: LANEW] = lane_val;
    end
  endgenerate

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      addb      <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      srcd_q    <= '0;
      iinc_q    <= '0;
      zinc_q    <= '0;
      ai        <= '0;
      az        <= '0;
    end else if (accept) begin
      state     <= BURST;
      out_valid <= 1'b1;
      out_last  <= (cmd_count == '0);
      addb      <= addb_next;
      sel_q     <= cmd_sel;
      cnt_q     <= cmd_count;
      srcd_q    <= srcd;
      iinc_q    <= iinc[31:16];
      zinc_q    <= zinc;
      ai        <= ai_m;
      az        <= az_m;
    end else if (advance) begin
      if (out_last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        // cnt_q counts beats still to come after the one currently presented.
        cnt_q    <= cnt_q - CNTW'(1);
        out_last <= (cnt_q == CNTW'(1));
        addb     <= addb_next;
        ai       <= ai_m;
        az       <= az_m;
      end
    end
  end

endmodule
